// File: rtl/seq_pattern_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx_pkg
//  Brief    : Shared constants for the serial pattern link: FSM state
//             encoding of the transmitter and the idle level of the link.
//  Revision : 1.0 - initial release
// ============================================================================
package seq_pattern_tx_pkg;

    // Transmitter FSM state encoding (also exported on the debug state port)
    localparam logic [1:0] c_ST_IDLE = 2'b00;
    localparam logic [1:0] c_ST_SEND = 2'b01;
    localparam logic [1:0] c_ST_GAP  = 2'b10;
    localparam logic [1:0] c_ST_DONE = 2'b11;

    // Level driven on the serial line whenever no pattern bit is carried
    localparam logic c_LINK_IDLE = 1'b0;

endpackage
`default_nettype wire

// File: rtl/seq_pattern_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx_if
//  Brief    : Request/serial-output bundle of the pattern transmitter.
//             master = requester side, slave = transmitter side.
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_pattern_tx_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 4
);

    logic             start;
    logic [PAT_W-1:0] pattern_in;
    logic [CNT_W-1:0] reps_in;
    logic             abort;
    logic             data_out;
    logic             data_valid;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, pattern_in, reps_in, abort,
        input  data_out, data_valid, busy, done, state
    );

    modport slave (
        input  start, pattern_in, reps_in, abort,
        output data_out, data_valid, busy, done, state
    );

endinterface
`default_nettype wire

// File: rtl/seq_pattern_tx_piso_shift.sv
`default_nettype none
// ============================================================================
//  Module   : piso_shift
//  Brief    : Parallel-load, MSB-first shift register with a registered
//             serial output. A load puts the MSB on the output immediately
//             (next cycle) and keeps the remaining bits for later shifts.
//             clear > load > shift.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_shift
    import seq_pattern_tx_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             load,
    input  wire logic             shift,
    input  wire logic [WIDTH-1:0] load_data,
    output logic                  serial_out
);

    logic [WIDTH-1:0] r_sr;
    logic             r_out;

    // Load/shift the register; the output bit is always a flop, never a gate
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sr  <= '0;
            r_out <= c_LINK_IDLE;
        end else if (clear) begin
            r_sr  <= '0;
            r_out <= c_LINK_IDLE;
        end else if (load) begin
            r_out <= load_data[WIDTH-1];
            r_sr  <= {load_data[WIDTH-2:0], 1'b0};
        end else if (shift) begin
            r_out <= r_sr[WIDTH-1];
            r_sr  <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign serial_out = r_out;

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : seq_pattern_tx
//  Brief    : Serial pattern transmitter. Shifts a captured PAT_W-bit
//             pattern out MSB-first a programmable number of times, with
//             GAP_CYC idle cycles between repetitions, then pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_pattern_tx
    import seq_pattern_tx_pkg::*;
#(
    parameter int PAT_W   = 3,
    parameter int CNT_W   = 4,
    parameter int GAP_CYC = 1
) (
    input  wire logic       clk,
    input  wire logic       reset,
    seq_pattern_tx_if.slave bus
);

    localparam int c_BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int c_GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(PAT_W - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0]   c_ONE_REP  = CNT_W'(1);
    localparam logic               c_NO_GAP   = (GAP_CYC == 0);

    logic [1:0]         r_state;
    logic               r_valid;
    logic               r_busy;
    logic               r_done;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0]   r_rep_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [PAT_W-1:0]   r_pat_hold;

    logic               w_last_bit;
    logic               w_more_reps;
    logic               w_gap_end;
    logic               w_sr_clear;
    logic               w_sr_load;
    logic               w_sr_shift;
    logic [PAT_W-1:0]   w_sr_data;
    logic               w_serial;

    assign w_last_bit  = (r_state == c_ST_SEND) && (r_bit_cnt == c_LAST_BIT);
    assign w_more_reps = (r_rep_cnt != c_ONE_REP);
    assign w_gap_end   = (r_state == c_ST_GAP) && (r_gap_cnt == c_GAP_LAST);

    // Shift-register control: decides which bit is on the wire next cycle
    always_comb begin
        w_sr_clear = 1'b0;
        w_sr_load  = 1'b0;
        w_sr_shift = 1'b0;
        w_sr_data  = r_pat_hold;
        if (bus.abort) begin
            w_sr_clear = 1'b1;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start && (bus.reps_in != '0)) begin
                        w_sr_load = 1'b1;
                        w_sr_data = bus.pattern_in;
                    end else begin
                        w_sr_clear = 1'b1;
                    end
                end
                c_ST_SEND: begin
                    if (!w_last_bit) begin
                        w_sr_shift = 1'b1;
                    end else if (w_more_reps && c_NO_GAP) begin
                        w_sr_load = 1'b1;
                    end else begin
                        w_sr_clear = 1'b1;
                    end
                end
                c_ST_GAP: begin
                    w_sr_load = w_gap_end;
                end
                default: begin
                    w_sr_clear = 1'b1;
                end
            endcase
        end
    end

    piso_shift #(
        .WIDTH (PAT_W)
    ) u_piso_shift (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_sr_clear),
        .load       (w_sr_load),
        .shift      (w_sr_shift),
        .load_data  (w_sr_data),
        .serial_out (w_serial)
    );

    // Transmitter FSM with its counters and registered status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_ST_IDLE;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bit_cnt  <= '0;
            r_rep_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_pat_hold <= '0;
        end else if (bus.abort) begin
            // Cancel wins over every other transition, including a start in IDLE
            r_state   <= c_ST_IDLE;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_pat_hold <= bus.pattern_in;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= '0;
                        if (bus.reps_in != '0) begin
                            r_rep_cnt <= bus.reps_in;
                            r_valid   <= 1'b1;
                            r_state   <= c_ST_SEND;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_SEND: begin
                    if (w_last_bit) begin
                        r_rep_cnt <= r_rep_cnt - c_ONE_REP;
                        r_bit_cnt <= '0;
                        if (!w_more_reps) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_ST_DONE;
                        end else if (!c_NO_GAP) begin
                            r_valid   <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= c_ST_GAP;
                        end
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    if (w_gap_end) begin
                        r_valid   <= 1'b1;
                        r_bit_cnt <= '0;
                        r_state   <= c_ST_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    // DONE lasts one cycle; start is not looked at here
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = w_serial;
    assign bus.data_valid = r_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_pattern_tx
//  Brief    : Bench for seq_pattern_tx. Two instances (GAP_CYC=1 and
//             GAP_CYC=0) share one stimulus stream; each is compared every
//             cycle against a job-timeline model, plus literal checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_pattern_tx;

    localparam int PAT_W = 3;
    localparam int CNT_W = 4;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             tb_start   = 1'b0;
    logic [PAT_W-1:0] tb_pattern = '0;
    logic [CNT_W-1:0] tb_reps    = '0;
    logic             tb_abort   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if_g1 ();
    seq_pattern_tx_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if_g0 ();

    assign if_g1.start      = tb_start;
    assign if_g1.pattern_in = tb_pattern;
    assign if_g1.reps_in    = tb_reps;
    assign if_g1.abort      = tb_abort;
    assign if_g0.start      = tb_start;
    assign if_g0.pattern_in = tb_pattern;
    assign if_g0.reps_in    = tb_reps;
    assign if_g0.abort      = tb_abort;

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(1)) u_dut_g1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_g1)
    );

    seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_CYC(0)) u_dut_g0 (
        .clk   (clk),
        .reset (reset),
        .bus   (if_g0)
    );

    always #5 clk = ~clk;

    // ---------------- comparison helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A job is a timeline: cycle k (1-based after acceptance) is a pattern
    // bit, a gap cycle or the final done cycle, derived from arithmetic.
    int             m_active [2] = '{0, 0};
    int             m_k      [2] = '{0, 0};
    int             m_reps   [2] = '{0, 0};
    logic [PAT_W-1:0] m_pat  [2];
    int             m_gap    [2] = '{1, 0};

    function automatic int job_len(input int reps, input int gap);
        if (reps == 0) return 0;
        return reps * PAT_W + (reps - 1) * gap;
    endfunction

    // {state[1:0], data_out, data_valid, busy, done}
    function automatic logic [5:0] exp_out(input int active, input int k,
                                           input logic [PAT_W-1:0] pat,
                                           input int reps, input int gap);
        int pos;
        if (active == 0) return 6'b00_0000;
        if (k == job_len(reps, gap) + 1) return 6'b11_0011;
        pos = (k - 1) % (PAT_W + gap);
        if (pos < PAT_W) return {2'b01, pat[PAT_W-1-pos], 3'b110};
        return 6'b10_0010;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            for (int i = 0; i < 2; i++) begin
                if (!reset) begin
                    m_active[i] = 0;
                end else if (tb_abort) begin
                    m_active[i] = 0;
                end else if (m_active[i] != 0) begin
                    m_k[i] = m_k[i] + 1;
                    if (m_k[i] > job_len(m_reps[i], m_gap[i]) + 1) m_active[i] = 0;
                end else if (tb_start) begin
                    m_active[i] = 1;
                    m_k[i]      = 1;
                    m_pat[i]    = tb_pattern;
                    m_reps[i]   = int'(tb_reps);
                end
            end
        end
    end

    // Per-cycle compare of both instances against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("g1_outputs", {if_g1.state, if_g1.data_out, if_g1.data_valid, if_g1.busy, if_g1.done},
                exp_out(m_active[0], m_k[0], m_pat[0], m_reps[0], m_gap[0]));
            chk("g0_outputs", {if_g0.state, if_g0.data_out, if_g0.data_valid, if_g0.busy, if_g0.done},
                exp_out(m_active[1], m_k[1], m_pat[1], m_reps[1], m_gap[1]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic launch(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] reps);
        tb_start   = 1'b1;
        tb_pattern = pat;
        tb_reps    = reps;
        tick();
        tb_start   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tb_start = 1'b0;
        tb_abort = 1'b0;
        while ((if_g1.busy || if_g0.busy) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", (n < 200), 1);
        tick();
    endtask

    logic [13:0] exp_s2;
    logic [2:0]  win;
    int          nvalid;
    int          hits;
    logic [8:0]  bits9;

    initial begin
        // Reset state, checked while reset is still asserted
        tick();
        chk("reset_g1", {if_g1.state, if_g1.data_out, if_g1.data_valid, if_g1.busy, if_g1.done}, 0);
        chk("reset_g0", {if_g0.state, if_g0.data_out, if_g0.data_valid, if_g0.busy, if_g0.done}, 0);
        tick();
        reset = 1'b1;
        tick();

        // Pattern 101, one repetition: bits in cycles 1..3, done in 4, idle after edge 5
        launch(3'b101, 4'd1);
        chk("t1_c1", {if_g1.data_out, if_g1.data_valid}, 2'b11);
        tick();
        chk("t1_c2", {if_g1.data_out, if_g1.data_valid}, 2'b01);
        tick();
        chk("t1_c3", {if_g1.data_out, if_g1.data_valid}, 2'b11);
        tick();
        chk("t1_done", {if_g1.done, if_g1.busy, if_g1.data_valid}, 3'b110);
        tick();
        chk("t1_busy_low", {if_g1.busy, if_g1.state}, 3'b000);
        wait_idle();

        // Pattern 101, two repetitions with one gap cycle
        exp_s2 = {2'b11, 2'b01, 2'b11, 2'b00, 2'b11, 2'b01, 2'b11};
        win = '0; nvalid = 0; hits = 0;
        launch(3'b101, 4'd2);
        for (int c = 1; c <= 7; c++) begin
            chk("t2_stream", {if_g1.data_out, if_g1.data_valid}, exp_s2[13-2*(c-1) -: 2]);
            if (if_g1.data_valid) begin
                win = {win[1:0], if_g1.data_out};
                nvalid++;
                if (nvalid >= 3 && win == 3'b101) hits++;
            end
            tick();
        end
        chk("t2_done_c8", if_g1.done, 1'b1);
        chk("t2_hits_101", hits, 2);
        wait_idle();

        // Pattern 110, three repetitions: gapless instance is contiguous
        bits9 = '0; nvalid = 0;
        launch(3'b110, 4'd3);
        for (int c = 1; c <= 9; c++) begin
            if (if_g0.data_valid) begin
                bits9 = {bits9[7:0], if_g0.data_out};
                nvalid++;
            end
            tick();
        end
        chk("t3_bits", bits9, 9'b110110110);
        chk("t3_nvalid", nvalid, 9);
        chk("t3_done_c10", {if_g0.done, if_g0.data_valid}, 2'b10);
        wait_idle();

        // Zero repetitions: straight to DONE, then IDLE
        launch(3'b111, 4'd0);
        chk("t4_done_state", {if_g1.state, if_g1.done, if_g1.data_valid}, 4'b1110);
        tick();
        chk("t4_idle_state", {if_g1.state, if_g1.done}, 3'b000);
        wait_idle();

        // Abort in cycle 5 of a four-repetition job, then a fresh start
        launch(3'b011, 4'd4);
        for (int c = 1; c < 5; c++) tick();
        tb_abort = 1'b1;
        tick();
        tb_abort = 1'b0;
        chk("t5_abort_g1", {if_g1.state, if_g1.data_valid, if_g1.busy}, 4'b0000);
        chk("t5_abort_g0", {if_g0.state, if_g0.data_valid, if_g0.busy}, 4'b0000);
        for (int c = 0; c < 4; c++) begin
            chk("t5_no_done", if_g1.done | if_g0.done, 1'b0);
            tick();
        end
        launch(3'b011, 4'd1);
        chk("t5_restart", {if_g1.state, if_g1.data_out, if_g1.data_valid}, 4'b0101);
        wait_idle();

        // Abort together with start in IDLE: nothing starts
        tb_abort = 1'b1;
        launch(3'b101, 4'd2);
        tb_abort = 1'b0;
        chk("t5b_abort_start", {if_g1.state, if_g1.busy}, 3'b000);
        wait_idle();

        // Start while busy with another pattern is ignored
        launch(3'b101, 4'd2);
        tb_start   = 1'b1;
        tb_pattern = 3'b010;
        tb_reps    = 4'd7;
        tick();
        tb_start   = 1'b0;
        tick(); tick(); tick();
        chk("t6_rep2_msb", {if_g1.data_out, if_g1.data_valid}, 2'b11);
        wait_idle();

        // Asynchronous reset in the middle of SEND
        launch(3'b111, 4'd3);
        tick();
        #2 reset = 1'b0;
        #1;
        chk("t7_async_g1", {if_g1.state, if_g1.data_out, if_g1.data_valid, if_g1.busy, if_g1.done}, 0);
        chk("t7_async_g0", {if_g0.state, if_g0.data_out, if_g0.data_valid, if_g0.busy, if_g0.done}, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            tb_start   = ($urandom_range(0, 3) == 0);
            tb_pattern = PAT_W'($urandom);
            tb_reps    = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(0, 15))
                                                     : CNT_W'($urandom_range(0, 3));
            tb_abort   = ($urandom_range(0, 59) == 0);
            tick();
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
